dac_frame_sequencer: RTL and testbench
======================================

// Module: dac_frame_sequencer
// PURPOSE
// - Output-side controller between the filter datapath and the serial DAC: accepts signed N-bit
//   samples, saturates/truncates them to F-1-bit offset binary and holds one sample in a buffer.
// - Paces the output rate with an internal sample tick and serialises one 16-bit DAC frame per
//   tick on cs_n/sclk/mosi. Replaces the CS-edge-triggered truncation with a fully clocked path.
// PARAMETERS
// - N              16    input sample width, two's complement, sign at bit N-1
// - F              9     output width is F-1 (8); fraction field is din[F-3:0]
// - CLK_DIV        4     sclk half-period in clk cycles (>=1)
// - SAMPLE_PERIOD  2000  clk cycles between sample ticks
// - FRAME_CMD      4'b0011  command nibble sent ahead of data
// PORTS
// - clk          in   1    system clock, all logic on rising edge
// - reset_n      in   1    asynchronous active-low reset
// - din          in   N    signed sample from filter
// - din_valid    in   1    din valid this cycle
// - din_ready    out  1    buffer can accept; transfer when din_valid && din_ready
// - sample_tick  out  1    1-cycle pulse every SAMPLE_PERIOD clk; also requests next filter sample
// - cs_n         out  1    DAC chip select, active low
// - sclk         out  1    DAC serial clock, idle low
// - mosi         out  1    DAC serial data, MSB first
// - busy         out  1    high from frame launch until guard time ends
// - underrun     out  1    1-cycle pulse: tick found buffer empty
// - tick_missed  out  1    1-cycle pulse: tick arrived while busy (frame skipped)
// BEHAVIOUR
// - Reset: cs_n=1, sclk=0, mosi=0, busy=0, underrun=0, tick_missed=0, sample_tick=0,
//   buffer empty (din_ready=1), last_sent=8'h80, tick counter=0, FSM=IDLE. Reset mid-frame aborts
//   immediately to these values; no partial frame is completed.
// - Tick counter: 0..SAMPLE_PERIOD-1, wraps; sample_tick=1 when count==SAMPLE_PERIOD-1.
// - Saturation at acceptance: int=din[N-1:F-2]. If int not all equal to din[N-1]: positive -> 8'hFF,
//   negative -> 8'h00; else out={~din[N-1], din[F-3:0]}. Result registered into buffer, 1 cycle.
// - Buffer: one deep; din_ready=~buf_full (registered state only). Accept sets buf_full next cycle.
// - FSM IDLE->SHIFT on sample_tick: frame word={FRAME_CMD, data, 4'b0000}; data=buffer if
//   buf_full (buf_full cleared, last_sent<=data) else fallback + underrun pulse. cs_n falls and
//   mosi=bit15 on the cycle after the tick.
// - Tick and accept in same cycle with buffer empty: counts as underrun; accepted value stays
//   buffered for next tick.
// - SHIFT: per bit, sclk low CLK_DIV cycles then high CLK_DIV cycles; mosi changes only while
//   sclk low (on the falling edge / first low cycle); DAC samples on rising edge. 16 bits.
// - After bit0 high phase: cs_n=1, sclk=0, mosi=0 -> GUARD for CLK_DIV cycles -> IDLE, busy=0.
// - Frame length = 32*CLK_DIV + CLK_DIV cycles incl. guard; SAMPLE_PERIOD must be >=
//   33*CLK_DIV+2 (checked by simulation assertion). Tick while not IDLE -> tick_missed pulse,
//   frame not queued, buffer untouched.
// CONFIGURATION
// - DAC_UNDERRUN_HOLD_EN defined: underrun fallback = last_sent (zero-order hold).
// - Not defined: underrun fallback = 8'h80 (midscale); last_sent still tracked, unused.
// - underrun pulse generated in both cases.
// TESTING
// - Reset, no input, run 1 period -> tick at cycle 1999, underrun=1, frame 16'h3800 sent.
// - din=16'h007F (N=16,F=9) accepted, tick -> data 8'hFF? no: int all 0 -> data 8'hFF; frame 16'h3FF0.
// - din=16'h1234 -> saturate 8'hFF; din=16'hF000 -> 8'h00; din=16'hFF80 -> 8'h00, frame 16'h3000.
// - Sample 8'h5A sent, next tick empty -> HOLD_EN: frame 16'h35A0; else 16'h3800; underrun=1 both.
// - SAMPLE_PERIOD=100, CLK_DIV=4 -> tick during SHIFT gives tick_missed=1, no second frame, busy=1.
// - reset_n low during bit 7 of frame -> cs_n=1, sclk=0 same edge; next frame starts from bit15.

Source files
------------

// File: rtl/dac_frame_sequencer.sv
// Saturating one-deep sample buffer feeding a paced 16-bit serial DAC frame per sample tick.
// Define DAC_UNDERRUN_HOLD_EN to resend the last sample on underrun instead of midscale.
module dac_frame_sequencer #(
  parameter int unsigned N               = 16,
  parameter int unsigned F               = 9,
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned SAMPLE_PERIOD   = 2000,
  parameter logic [3:0]  FRAME_CMD       = 4'b0011,
  parameter bit          PERIOD_CHECK_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sample_tick,
  output logic         cs_n,
  output logic         sclk,
  output logic         mosi,
  output logic         busy,
  output logic         underrun,
  output logic         tick_missed
);
  localparam int unsigned DW  = F - 1;
  localparam int unsigned FW  = DW + 8;
  localparam int unsigned CW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW  = $clog2(FW);
  localparam int unsigned IW  = N - F + 2;
  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GUARD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_tick;
  logic            r_buf_full;
  logic [DW-1:0]   r_buf;
  logic [DW-1:0]   r_last;
  logic [FW-1:0]   r_shift;
  logic [BW-1:0]   r_bit;
  logic [DVW-1:0]  r_div;
  logic            r_cs_n;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_busy;
  logic            r_underrun;
  logic            r_tick_missed;

  logic [IW-1:0]   w_int;
  logic            w_ovf;
  logic [DW-1:0]   w_conv;
  logic [DW-1:0]   w_fallback;
  logic [DW-1:0]   w_data;
  logic [FW-1:0]   w_frame;
  logic            w_accept;
  logic            w_take;

  // Integer part must be pure sign extension, otherwise clamp to the rail of the sign.
  assign w_int = din[N-1:F-2];
  assign w_ovf = (w_int != {IW{din[N-1]}});

  always_comb begin
    w_conv = {~din[N-1], din[F-3:0]};
    if (w_ovf) begin
      w_conv = din[N-1] ? '0 : '1;
    end
  end

`ifdef DAC_UNDERRUN_HOLD_EN
  assign w_fallback = r_last;
`else
  assign w_fallback = MIDSCALE;
`endif

  assign w_accept = din_valid && !r_buf_full;
  assign w_take   = r_tick && (r_state == S_IDLE);
  assign w_data   = r_buf_full ? r_buf : w_fallback;
  assign w_frame  = {FRAME_CMD, w_data, 4'b0000};

  // Tick is registered one count early so it lines up with count == SAMPLE_PERIOD-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == CW'(SAMPLE_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == CW'(SAMPLE_PERIOD - 2));
    end
  end

  // A tick that finds the buffer empty leaves a same-cycle accept in place for the next tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_take && r_buf_full) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= w_conv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last        <= MIDSCALE;
      r_shift       <= '0;
      r_bit         <= '0;
      r_div         <= '0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_busy        <= 1'b0;
      r_underrun    <= 1'b0;
      r_tick_missed <= 1'b0;
    end else begin
      r_underrun    <= 1'b0;
      r_tick_missed <= 1'b0;
      if (r_tick && r_state != S_IDLE) begin
        r_tick_missed <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_tick) begin
            r_state    <= S_SHIFT;
            r_shift    <= w_frame;
            r_mosi     <= w_frame[FW-1];
            r_cs_n     <= 1'b0;
            r_sclk     <= 1'b0;
            r_busy     <= 1'b1;
            r_div      <= '0;
            r_bit      <= BW'(FW - 1);
            r_underrun <= ~r_buf_full;
            if (r_buf_full) begin
              r_last <= r_buf;
            end
          end
        end
        S_SHIFT: begin
          if (r_div == DVW'(CLK_DIV - 1)) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else if (r_bit == '0) begin
              r_state <= S_GUARD;
              r_cs_n  <= 1'b1;
              r_sclk  <= 1'b0;
              r_mosi  <= 1'b0;
            end else begin
              // Falling edge: present the next bit while sclk is low.
              r_sclk  <= 1'b0;
              r_bit   <= r_bit - 1'b1;
              r_shift <= {r_shift[FW-2:0], 1'b0};
              r_mosi  <= r_shift[FW-2];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GUARD: begin
          if (r_div == DVW'(CLK_DIV - 1)) begin
            r_div   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign din_ready   = ~r_buf_full;
  assign sample_tick = r_tick;
  assign cs_n        = r_cs_n;
  assign sclk        = r_sclk;
  assign mosi        = r_mosi;
  assign busy        = r_busy;
  assign underrun    = r_underrun;
  assign tick_missed = r_tick_missed;

  // A legal SAMPLE_PERIOD never lets a tick land inside a frame.
  a_tick_in_frame: assert property (@(posedge clk) disable iff (!reset_n)
    !(PERIOD_CHECK_EN && r_tick && r_state != S_IDLE))
    else $error("sample tick during active frame; SAMPLE_PERIOD below 33*CLK_DIV+2");

  a_last_stable: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_take && r_buf_full) |=> $stable(r_last))
    else $error("last_sent changed without a buffered frame launch");

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Randomised self-checking bench: frames are decoded from the serial pins and compared with
// a saturation/underrun model; a second short-period instance exercises skipped ticks.
module tb_dac_frame_sequencer;
  localparam int unsigned SP   = 2000;
  localparam int unsigned SP_F = 100;
`ifdef DAC_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, sample_tick, cs_n, sclk, mosi, busy, underrun, tick_missed;

  logic        rst_f_n = 1'b0;
  logic [15:0] din_f = '0;
  logic        din_valid_f = 1'b0;
  logic        din_ready_f, sample_tick_f, cs_n_f, sclk_f, mosi_f, busy_f, underrun_f, tick_missed_f;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_last = 8'h80;

  always #5 clk = ~clk;

  dac_frame_sequencer #(.N(16), .F(9), .CLK_DIV(4), .SAMPLE_PERIOD(SP), .FRAME_CMD(4'b0011))
  u_dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sample_tick(sample_tick), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .busy(busy),
    .underrun(underrun), .tick_missed(tick_missed)
  );

  dac_frame_sequencer #(.N(16), .F(9), .CLK_DIV(4), .SAMPLE_PERIOD(SP_F), .FRAME_CMD(4'b0011),
                        .PERIOD_CHECK_EN(1'b0))
  u_fast (
    .clk(clk), .reset_n(rst_f_n), .din(din_f), .din_valid(din_valid_f), .din_ready(din_ready_f),
    .sample_tick(sample_tick_f), .cs_n(cs_n_f), .sclk(sclk_f), .mosi(mosi_f), .busy(busy_f),
    .underrun(underrun_f), .tick_missed(tick_missed_f)
  );

  // Reference: clamp the signed sample to [-128,127] and offset by 128.
  function automatic logic [7:0] sat_model(input logic [15:0] d);
    int s;
    s = int'($signed(d));
    if (s > 127) return 8'hFF;
    if (s < -128) return 8'h00;
    return 8'(s + 128);
  endfunction

  function automatic logic [15:0] frame_of(input logic [7:0] d);
    return {4'b0011, d, 4'b0000};
  endfunction

  function automatic logic [7:0] fallback();
    return HOLD ? m_last : 8'h80;
  endfunction

  // Decodes one frame from the pins (mosi sampled on each sclk rise) and measures its timing.
  task automatic capture_frame(output logic [15:0] f, output int busy_cyc, output int cs_cyc,
                               output logic und, output logic glitch, output bit bad);
    int n, bits;
    logic ps, pm;
    f = '0; busy_cyc = 0; cs_cyc = 0; und = 1'b0; glitch = 1'b0; bad = 1'b0; bits = 0;
    n = 0;
    while (busy !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (busy !== 1'b1) begin bad = 1'b1; return; end
    und = underrun;
    ps = sclk; pm = mosi; n = 0;
    while (busy === 1'b1 && n < 1000) begin
      busy_cyc++;
      if (cs_n === 1'b0) cs_cyc++;
      if (sclk === 1'b1 && ps === 1'b0 && cs_n === 1'b0) begin f = {f[14:0], mosi}; bits++; end
      if (sclk === 1'b1 && ps === 1'b1 && mosi !== pm) glitch = 1'b1;
      ps = sclk; pm = mosi;
      @(negedge clk); n++;
    end
    if (busy === 1'b1 || bits != 16) bad = 1'b1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (n < 2 * SP) begin
      @(negedge clk); n++;
      if (sample_tick === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    reset_n = 1'b0; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    got = {cs_n, sclk, mosi, busy, underrun, tick_missed, sample_tick, din_ready};
    exp = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL reset_out%0d got %b want %b", i, got[i], exp[i]);
      end
    end
    m_last = 8'h80;
    reset_n = 1'b1;
  endtask

  task automatic test_no_input();
    int n, bc, cc; logic [15:0] f; logic u, g; bit bad;
    wait_tick(n);
    checks++;
    if (n != SP - 1) begin errors++; $display("FAIL first_tick cycle got %0d want %0d", n, SP - 1); end
    capture_frame(f, bc, cc, u, g, bad);
    checks++;
    if (bad || f !== frame_of(8'h80)) begin
      errors++; $display("FAIL empty_frame got %h want %h bad=%0d", f, frame_of(8'h80), bad);
    end
    checks++;
    if (u !== 1'b1) begin errors++; $display("FAIL empty_underrun got %b want 1", u); end
    checks++;
    if (bc != 33 * 4) begin errors++; $display("FAIL busy_len got %0d want %0d", bc, 33 * 4); end
    checks++;
    if (cc != 32 * 4) begin errors++; $display("FAIL cs_low_len got %0d want %0d", cc, 32 * 4); end
    checks++;
    if (g !== 1'b0) begin errors++; $display("FAIL mosi_stable got %b want 0", g); end
  endtask

  task automatic send_and_check(input logic [15:0] v, input string tag);
    int bc, cc; logic [15:0] f, exp; logic u, g; bit bad;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL %s ready_before got %b want 1", tag, din_ready); end
    din = v; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL %s ready_after got %b want 0", tag, din_ready); end
    capture_frame(f, bc, cc, u, g, bad);
    exp = frame_of(sat_model(v));
    m_last = sat_model(v);
    checks++;
    if (bad || f !== exp) begin errors++; $display("FAIL %s frame din=%h got %h want %h", tag, v, f, exp); end
    checks++;
    if (u !== 1'b0) begin errors++; $display("FAIL %s underrun got %b want 0", tag, u); end
  endtask

  task automatic test_saturation();
    logic [15:0] v;
    send_and_check(16'h007F, "sat_7f");
    send_and_check(16'h1234, "sat_pos");
    send_and_check(16'hF000, "sat_neg");
    send_and_check(16'hFF80, "sat_min");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) v = 16'($urandom);
      else v = 16'(int'($urandom_range(0, 599)) - 300);
      send_and_check(v, "sat_rand");
    end
  endtask

  task automatic test_hold();
    int bc, cc; logic [15:0] f, exp; logic u, g; bit bad;
    send_and_check(16'hFFDA, "hold_5a");
    capture_frame(f, bc, cc, u, g, bad);
    exp = frame_of(fallback());
    checks++;
    if (bad || f !== exp) begin errors++; $display("FAIL hold_frame got %h want %h", f, exp); end
    checks++;
    if (u !== 1'b1) begin errors++; $display("FAIL hold_underrun got %b want 1", u); end
  endtask

  task automatic test_tick_accept_same_cycle();
    int n, bc, cc; logic [15:0] f, v, exp; logic u, g; bit bad;
    v = 16'(int'($urandom_range(0, 255)) - 128);
    wait_tick(n);
    din = v; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (n < 0 || din_ready !== 1'b0) begin
      errors++; $display("FAIL coincide_buffered ready got %b want 0 tick=%0d", din_ready, n);
    end
    capture_frame(f, bc, cc, u, g, bad);
    exp = frame_of(fallback());
    checks++;
    if (bad || f !== exp || u !== 1'b1) begin
      errors++; $display("FAIL coincide_underrun frame got %h/%b want %h/1", f, u, exp);
    end
    capture_frame(f, bc, cc, u, g, bad);
    exp = frame_of(sat_model(v));
    m_last = sat_model(v);
    checks++;
    if (bad || f !== exp || u !== 1'b0) begin
      errors++; $display("FAIL coincide_next frame got %h/%b want %h/0", f, u, exp);
    end
  endtask

  task automatic test_reset_midframe();
    int n, rises, bc, cc; logic [15:0] f; logic ps, u, g; bit bad;
    @(negedge clk);
    din = 16'h0048; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    rises = 0; ps = sclk; n = 0;
    while (rises < 8 && n < 1000) begin
      @(negedge clk); n++;
      if (sclk === 1'b1 && ps === 1'b0) rises++;
      ps = sclk;
    end
    n = 0;
    while (sclk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (mosi !== 1'b1 || cs_n !== 1'b0) begin
      errors++; $display("FAIL midframe_bit7 mosi/cs_n got %b/%b want 1/0", mosi, cs_n);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cs_n, sclk, mosi, busy, din_ready} !== 5'b10001) begin
      errors++; $display("FAIL midframe_abort cs,sclk,mosi,busy,rdy got %b want 10001",
                         {cs_n, sclk, mosi, busy, din_ready});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_last = 8'h80;
    wait_tick(n);
    checks++;
    if (n != SP - 1) begin errors++; $display("FAIL midframe_tick got %0d want %0d", n, SP - 1); end
    capture_frame(f, bc, cc, u, g, bad);
    checks++;
    if (bad || f !== frame_of(fallback()) || u !== 1'b1) begin
      errors++; $display("FAIL midframe_restart got %h/%b want %h/1", f, u, frame_of(fallback()));
    end
  endtask

  task automatic test_tick_missed();
    int first_tick, miss_cnt, miss_at, falls;
    logic prev_cs, und100, busy200, cs200, cs300;
    first_tick = -1; miss_cnt = 0; miss_at = -1; falls = 0; prev_cs = 1'b1;
    und100 = 1'b0; busy200 = 1'b0; cs200 = 1'b1; cs300 = 1'b1;
    @(negedge clk);
    rst_f_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (sample_tick_f === 1'b1 && first_tick < 0) first_tick = n;
      if (tick_missed_f === 1'b1) begin miss_cnt++; if (miss_at < 0) miss_at = n; end
      if (n < 300 && prev_cs === 1'b1 && cs_n_f === 1'b0) falls++;
      if (n == 100) und100 = underrun_f;
      if (n == 200) begin busy200 = busy_f; cs200 = cs_n_f; end
      if (n == 300) cs300 = cs_n_f;
      prev_cs = cs_n_f;
    end
    checks++;
    if (first_tick != SP_F - 1) begin errors++; $display("FAIL fast_tick got %0d want %0d", first_tick, SP_F - 1); end
    checks++;
    if (und100 !== 1'b1) begin errors++; $display("FAIL fast_underrun got %b want 1", und100); end
    checks++;
    if (miss_cnt != 1 || miss_at != 2 * SP_F) begin
      errors++; $display("FAIL tick_missed count/at got %0d/%0d want 1/%0d", miss_cnt, miss_at, 2 * SP_F);
    end
    checks++;
    if (busy200 !== 1'b1 || cs200 !== 1'b0) begin
      errors++; $display("FAIL missed_busy busy/cs_n got %b/%b want 1/0", busy200, cs200);
    end
    checks++;
    if (falls != 1) begin errors++; $display("FAIL missed_frames got %0d want 1", falls); end
    checks++;
    if (cs300 !== 1'b0) begin errors++; $display("FAIL next_frame cs_n got %b want 0", cs300); end
  endtask

  initial begin
    test_reset();
    test_no_input();
    test_saturation();
    test_hold();
    test_tick_accept_same_cycle();
    test_reset_midframe();
    test_tick_missed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
